// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding one registered output stage.
// The grant locks to a requester until its LAST beat is accepted (HOLD_LAST=1).
//
// state | meaning
// IDLE  | no packet in flight; grant decided combinationally, PRI breaks ties
// LOCK0 | A0 owns the channel until its LAST beat is accepted
// LOCK1 | A1 owns the channel until its LAST beat is accepted
module mux2_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             A0_VALID,
  input  logic [WIDTH-1:0] A0_DATA,
  input  logic             A0_LAST,
  output logic             A0_READY,
  input  logic             A1_VALID,
  input  logic [WIDTH-1:0] A1_DATA,
  input  logic             A1_LAST,
  output logic             A1_READY,
  output logic             Z_VALID,
  output logic [WIDTH-1:0] Z_DATA,
  output logic             Z_LAST,
  input  logic             Z_READY,
  output logic             SL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   pri, pri_nxt;
  logic   adv;
  logic   acc0, acc1, acc;
  logic   beat_last, pkt_end;

  assign adv = ~Z_VALID | Z_READY;

  // In IDLE each READY looks only at the other side's VALID and PRI, so the
  // two READYs can both be high when nobody is valid, but never both accept.
  always_comb begin
    A0_READY = 1'b0;
    A1_READY = 1'b0;
    case (state)
      IDLE: begin
        A0_READY = adv & (~A1_VALID | ~pri);
        A1_READY = adv & (~A0_VALID | pri);
      end
      LOCK0:   A0_READY = adv;
      LOCK1:   A1_READY = adv;
      default: begin
        A0_READY = 1'b0;
        A1_READY = 1'b0;
      end
    endcase
  end

  assign acc0      = A0_VALID & A0_READY;
  assign acc1      = A1_VALID & A1_READY;
  assign acc       = acc0 | acc1;
  assign beat_last = acc1 ? A1_LAST : A0_LAST;
  assign pkt_end   = beat_last | ~HOLD_LAST;

  always_comb begin
    state_nxt = state;
    pri_nxt   = pri;
    if (acc) begin
      if (pkt_end) begin
        state_nxt = IDLE;
        pri_nxt   = acc0;
      end else begin
        state_nxt = acc1 ? LOCK1 : LOCK0;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      pri   <= 1'b0;
    end else begin
      state <= state_nxt;
      pri   <= pri_nxt;
    end
  end

  // Payload registers hold their value on a drained cycle; only Z_VALID drops.
  always_ff @(posedge CK) begin
    if (RST) begin
      Z_VALID <= 1'b0;
      Z_DATA  <= '0;
      Z_LAST  <= 1'b0;
      SL      <= 1'b0;
    end else if (adv) begin
      Z_VALID <= acc;
      if (acc) begin
        Z_DATA <= acc1 ? A1_DATA : A0_DATA;
        Z_LAST <= pkt_end;
        SL     <= acc1;
      end
    end
  end

endmodule
